cnt_arbiter: RTL and testbench
==============================

# cnt_arbiter

Round-robin scheduler that shares one WIDTH-bit up-counter (timer resource) among NUM_REQ requesters. Each requester asks for a count of length `req_len`; the block grants one requester at a time, clears and runs the shared counter until it reaches the requested length, then pulses `done` and moves to the next requester. It sits between requesting control logic and the counter datapath, and owns all sequencing of that counter.

## Interface
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `WIDTH`, default 4: counter and length width.

- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester request level; held high until `done` for that requester.
- `req_len`  in  NUM_REQ*WIDTH  packed lengths; requester i uses bits [i*WIDTH +: WIDTH]. Sampled only at grant.
- `gnt`  out  NUM_REQ  one-hot grant; all-zero when idle.
- `busy`  out  1  high in RUN and DONE.
- `count_out`  out  WIDTH  current shared counter value.
- `done`  out  1  one-cycle pulse at job end.
- `done_id`  out  $clog2(NUM_REQ)  index of the finished requester, valid with `done`.
- `aborted`  out  1  valid with `done`; 1 if the job ended by request withdrawal.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if any `req` bit is high, select the first high bit searching upward from `(last_id+1) mod NUM_REQ`, wrapping. Latch `cur_id` and `cur_len`, set `gnt[cur_id]`, clear the counter to 0, and go to RUN. With no request, stay in IDLE with the counter held at 0.
- RUN, checked in priority order:
  - `req[cur_id]` low: go to DONE with `aborted`=1.
  - `count_out == cur_len`: go to DONE with `aborted`=0.
  - Otherwise increment the counter by 1.
- DONE: `done`=1 and `done_id`=`cur_id` for exactly one cycle. `gnt` is still asserted. Next edge: set `last_id`=`cur_id`, clear `gnt`, clear the counter, go to IDLE.
- Counter saturates at 2^WIDTH-1. It never wraps, because `cur_len` ≤ 2^WIDTH-1.
- Requests from non-granted requesters are ignored until IDLE. No preemption.
- If a requester keeps `req` high after its `done`, it is re-arbitrated normally. Round robin lets every other pending requester go first.
- Changes to `req_len` after grant have no effect.

## Timing
- Reset (asynchronous, active-low) forces:
  - state IDLE;
  - `gnt`=0, `busy`=0, `count_out`=0, `done`=0, `done_id`=0, `aborted`=0;
  - `last_id`=NUM_REQ-1, so requester 0 wins the first arbitration.
- Reset asserted mid-job aborts the job silently: no `done` pulse.
- `req` high before edge E0: `gnt` and `busy` high after E0, with `count_out`=0.
- Job of length L with no abort:
  - RUN lasts L+1 cycles, with `count_out` going 0..L;
  - `done` is high in the cycle after RUN;
  - back in IDLE one edge later.
  - Total grant-to-IDLE time is L+2 cycles. Minimum request-to-next-grant spacing is L+3 edges.
- L=0: one RUN cycle, then DONE.
- Abort: `req[cur_id]` low when sampled at edge Ek in RUN gives `done`=1 and `aborted`=1 after Ek. `count_out` freezes at its value before Ek.
- Abort and count match at the same edge: abort wins, `aborted`=1.
- `done`, `done_id` and `aborted` are registered outputs. `gnt`, `busy` and `count_out` are registered as well.

## Structure
- Package `cnt_arb_pkg` holds:
  - the state enum typedef `cnt_arb_state_t` (IDLE, RUN, DONE);
  - default-width constant `CNT_ARB_WIDTH`=4.
- One sub-module, `cnt_core`: WIDTH-bit up-counter with synchronous clear, enable and saturate-at-max. Clock `clk`, asynchronous active-low `reset`, output `output_data`.
- The arbiter FSM, round-robin priority logic and length comparator live in `cnt_arbiter`.

## Test plan
- Reset, then `req`=2'b01 with len0=3 → `gnt`=01 after next edge; `count_out` 0,1,2,3; `done`=1 with `done_id`=0 and `aborted`=0 in the 5th cycle after grant; `gnt`=0 after that.
- Both `req` high continuously, len0=2, len1=1 → grants alternate 0,1,0,1. `done` pulses 4 and 3 cycles after each respective grant, and the next grant follows 1 edge after returning to IDLE.
- len=0 on requester 1 only → `done` in the 2nd cycle after grant; `count_out` stays 0.
- len0=15, drop `req[0]` when `count_out`=6 → `done`=1 with `aborted`=1; `count_out` holds 6 during DONE; back in IDLE next edge.
- Assert `reset` mid-RUN at `count_out`=5 → all outputs 0 immediately (asynchronous), no `done` pulse. After release with both `req` high, requester 0 is granted first.
- Change `req_len` of the granted requester from 3 to 9 during RUN → job still ends at `count_out`=3.

Source files
------------

// File: rtl/cnt_arb_pkg.sv
// Shared definitions for the counter arbiter slice.
//   cnt_arb_state_t : arbiter FSM states (idle, running a job, reporting completion)
//   CNT_ARB_WIDTH   : default counter / job-length width
package cnt_arb_pkg;

   localparam int unsigned CNT_ARB_WIDTH = 4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } cnt_arb_state_t;

endpackage

// File: rtl/cnt_core.sv
// WIDTH-bit up-counter with synchronous clear, count enable and saturation at all-ones.
//   clk         : clock, rising edge
//   reset       : asynchronous active-low reset, forces count to 0
//   clr         : synchronous clear (wins over en)
//   en          : increment by one when not saturated
//   output_data : current count
module cnt_core
   import cnt_arb_pkg::*;
#(
   parameter int unsigned WIDTH = CNT_ARB_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] output_data
);

   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && (cnt_q != '1)) begin
         cnt_q <= cnt_q + WIDTH'(1);
      end
   end

   assign output_data = cnt_q;

endmodule

// File: rtl/cnt_arbiter.sv
// Round-robin scheduler sharing one up-counter among NUM_REQ requesters. A granted requester
// gets the counter cleared and run from 0 up to its latched length; the job then reports
// done for one cycle and the next requester is arbitrated.
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset (a job in flight is dropped without done)
//   req       : per-requester request level, held until its done
//   req_len   : packed job lengths, requester i at [i*WIDTH +: WIDTH], sampled at grant
//   gnt       : one-hot grant, zero when idle
//   busy      : high while a job runs or reports done
//   count_out : shared counter value
//   done      : one-cycle job-end pulse
//   done_id   : finished requester index, valid with done
//   aborted   : job ended by request withdrawal, valid with done
module cnt_arbiter
   import cnt_arb_pkg::*;
#(
   parameter int unsigned  NUM_REQ = 2,
   parameter int unsigned  WIDTH   = CNT_ARB_WIDTH,
   localparam int unsigned IdW     = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] req_len,
   output logic [NUM_REQ-1:0]       gnt,
   output logic                     busy,
   output logic [WIDTH-1:0]         count_out,
   output logic                     done,
   output logic [IdW-1:0]           done_id,
   output logic                     aborted
);

   cnt_arb_state_t   state_q;
   logic [IdW-1:0]   cur_id_q;
   logic [IdW-1:0]   last_id_q;
   logic [WIDTH-1:0] cur_len_q;
   logic [NUM_REQ-1:0] gnt_q;
   logic             busy_q;
   logic             done_q;
   logic [IdW-1:0]   done_id_q;
   logic             aborted_q;

   logic             pick_valid;
   logic [IdW-1:0]   pick_id;
   logic [IdW-1:0]   cand_id;
   logic             len_hit;
   logic             cnt_clr;
   logic             cnt_en;

   // Scan from last_id+1 upward with wrap. The loop runs from the farthest candidate to the
   // nearest so the nearest pending requester is the final assignment.
   always_comb begin
      pick_valid = 1'b0;
      pick_id    = '0;
      cand_id    = '0;
      for (int unsigned i = NUM_REQ; i >= 1; i--) begin
         cand_id = IdW'((32'(last_id_q) + i) % NUM_REQ);
         if (req[cand_id]) begin
            pick_valid = 1'b1;
            pick_id    = cand_id;
         end
      end
   end

   assign len_hit = (count_out == cur_len_q);
   // Counter is held at 0 outside RUN; it freezes on the exit edge so DONE shows the final
   // value, and the DONE->IDLE edge clears it.
   assign cnt_clr = (state_q != StRun);
   assign cnt_en  = (state_q == StRun) && req[cur_id_q] && !len_hit;

   cnt_core #(
      .WIDTH(WIDTH)
   ) u_cnt_core (
      .clk        (clk),
      .reset      (reset),
      .clr        (cnt_clr),
      .en         (cnt_en),
      .output_data(count_out)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         cur_id_q  <= '0;
         last_id_q <= IdW'(NUM_REQ - 1);
         cur_len_q <= '0;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         aborted_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pick_valid) begin
                  state_q         <= StRun;
                  cur_id_q        <= pick_id;
                  cur_len_q       <= req_len[pick_id*WIDTH +: WIDTH];
                  gnt_q           <= '0;
                  gnt_q[pick_id]  <= 1'b1;
                  busy_q          <= 1'b1;
               end
            end
            StRun: begin
               // Withdrawal takes priority over a simultaneous length match.
               if (!req[cur_id_q]) begin
                  state_q   <= StDone;
                  done_q    <= 1'b1;
                  done_id_q <= cur_id_q;
                  aborted_q <= 1'b1;
               end else if (len_hit) begin
                  state_q   <= StDone;
                  done_q    <= 1'b1;
                  done_id_q <= cur_id_q;
                  aborted_q <= 1'b0;
               end
            end
            StDone: begin
               state_q   <= StIdle;
               last_id_q <= cur_id_q;
               gnt_q     <= '0;
               busy_q    <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               gnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt     = gnt_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign done_id = done_id_q;
   assign aborted = aborted_q;

endmodule

// File: tb/tb_cnt_arbiter.sv
module tb_cnt_arbiter;

   localparam int unsigned NUM_REQ = 2;
   localparam int unsigned WIDTH   = 4;

   logic                     clk;
   logic                     reset;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] req_len;
   logic [NUM_REQ-1:0]       gnt;
   logic                     busy;
   logic [WIDTH-1:0]         count_out;
   logic                     done;
   logic [0:0]               done_id;
   logic                     aborted;

   cnt_arbiter #(
      .NUM_REQ(NUM_REQ),
      .WIDTH  (WIDTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .req_len  (req_len),
      .gnt      (gnt),
      .busy     (busy),
      .count_out(count_out),
      .done     (done),
      .done_id  (done_id),
      .aborted  (aborted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int id;
      int ab;
      int cnt;
      int lat;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push_exp(input int id, input int ab, input int cnt, input int lat);
      exp_t e;
      e.id  = id;
      e.ab  = ab;
      e.cnt = cnt;
      e.lat = lat;
      sb_q.push_back(e);
   endtask

   // Monitor: grant-to-done latency in negedges, and done fields against the scoreboard.
   initial begin
      int   cyc = 0;
      int   grant_cyc = 0;
      logic [NUM_REQ-1:0] prev_gnt = '0;
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) begin
            prev_gnt = '0;
         end else begin
            if ((gnt != '0) && (prev_gnt == '0)) grant_cyc = cyc;
            if (done) begin
               if (sb_q.size() == 0) begin
                  check_eq("unexpected_done", 1, 0);
               end else begin
                  e = sb_q.pop_front();
                  check_eq("sb_done_id", int'(done_id), e.id);
                  check_eq("sb_aborted", int'(aborted), e.ab);
                  check_eq("sb_count", int'(count_out), e.cnt);
                  check_eq("sb_latency", cyc - grant_cyc, e.lat);
                  check_eq("sb_gnt_in_done", int'(gnt), 1 << e.id);
                  check_eq("sb_busy_in_done", int'(busy), 1);
               end
            end
            prev_gnt = gnt;
         end
      end
   end

   task automatic wait_done(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 64);
      if (!done) check_eq({tag, "_timeout"}, 0, 1);
   endtask

   task automatic wait_count(input string tag, input int val);
      int n = 0;
      while ((int'(count_out) != val) && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (int'(count_out) != val) check_eq({tag, "_timeout"}, int'(count_out), val);
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_gnt"}, int'(gnt), 0);
      check_eq({tag, "_busy"}, int'(busy), 0);
      check_eq({tag, "_count"}, int'(count_out), 0);
   endtask

   initial begin
      reset   = 1'b0;
      req     = '0;
      req_len = '0;
      repeat (2) @(negedge clk);
      check_idle("rst");
      check_eq("rst_done", int'(done), 0);
      check_eq("rst_done_id", int'(done_id), 0);
      check_eq("rst_aborted", int'(aborted), 0);
      reset = 1'b1;
      @(negedge clk);

      // Single job, requester 0, length 3.
      req     = 2'b01;
      req_len = {4'd0, 4'd3};
      push_exp(0, 0, 3, 4);
      @(negedge clk);
      check_eq("t1_gnt", int'(gnt), 1);
      check_eq("t1_busy", int'(busy), 1);
      check_eq("t1_count0", int'(count_out), 0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check_eq("t1_count", int'(count_out), k);
         check_eq("t1_no_done", int'(done), 0);
      end
      @(negedge clk);
      check_eq("t1_done", int'(done), 1);
      req = '0;
      @(negedge clk);
      check_idle("t1_idle");

      // Zero-length job on requester 1.
      req     = 2'b10;
      req_len = {4'd0, 4'd3};
      push_exp(1, 0, 0, 1);
      @(negedge clk);
      check_eq("t2_gnt", int'(gnt), 2);
      check_eq("t2_count", int'(count_out), 0);
      @(negedge clk);
      check_eq("t2_done", int'(done), 1);
      check_eq("t2_count_done", int'(count_out), 0);
      req = '0;
      @(negedge clk);
      check_idle("t2_idle");

      // Both requesting continuously: grants alternate 0,1,0,1.
      req     = 2'b11;
      req_len = {4'd1, 4'd2};
      push_exp(0, 0, 2, 3);
      push_exp(1, 0, 1, 2);
      push_exp(0, 0, 2, 3);
      push_exp(1, 0, 1, 2);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check_eq("t3_gnt", int'(gnt), 1 << (j % 2));
         wait_done("t3_done");
         if (j == 3) req = '0;
         @(negedge clk);
         check_eq("t3_idle_gnt", int'(gnt), 0);
      end

      // Abort: requester 0 length 15, withdrawn at count 6.
      req     = 2'b01;
      req_len = {4'd0, 4'd15};
      push_exp(0, 1, 6, 7);
      @(negedge clk);
      wait_count("t4_count6", 6);
      req = '0;
      wait_done("t4_done");
      check_eq("t4_aborted", int'(aborted), 1);
      check_eq("t4_count_hold", int'(count_out), 6);
      @(negedge clk);
      check_idle("t4_idle");

      // Length change after grant is ignored.
      req     = 2'b01;
      req_len = {4'd0, 4'd3};
      push_exp(0, 0, 3, 4);
      @(negedge clk);
      check_eq("t5_gnt", int'(gnt), 1);
      req_len = {4'd0, 4'd9};
      wait_done("t5_done");
      check_eq("t5_count", int'(count_out), 3);
      req = '0;
      @(negedge clk);
      check_idle("t5_idle");

      // Asynchronous reset mid-job: no done for the dropped job.
      req     = 2'b10;
      req_len = {4'd15, 4'd0};
      @(negedge clk);
      check_eq("t6_gnt", int'(gnt), 2);
      wait_count("t6_count5", 5);
      #2 reset = 1'b0;
      #1;
      check_idle("t6_async");
      check_eq("t6_done", int'(done), 0);
      req     = 2'b11;
      req_len = {4'd1, 4'd1};
      push_exp(0, 0, 1, 2);
      push_exp(1, 0, 1, 2);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_eq("t6_first_gnt", int'(gnt), 1);
      wait_done("t6_done0");
      wait_done("t6_done1");
      req = '0;
      repeat (4) @(negedge clk);
      check_idle("end_idle");
      check_eq("sb_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
